// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: two-digit BCD counter (tens/ones) advanced by rising
// edges of an upstream divider level (tick_in), modulo MODULUS, up or down.
// A one-cycle carry pulse marks every wrap so stages can be cascaded.
// Optional feature macro: BCD_CNT_LOAD_EN adds the load/load_val ports.
module bcd_tick_counter #(
  parameter int MODULUS = 60
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       tick_in,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
`ifdef BCD_CNT_LOAD_EN
  input  logic       load,
  input  logic [7:0] load_val,
`endif
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  // Highest legal value MODULUS-1, split into BCD digits.
  localparam logic [3:0] TENS_MAX = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] ONES_MAX = 4'((MODULUS - 1) % 10);

  logic       tick_d;
  logic       step;
  logic       at_max;
  logic       at_zero;
  logic       do_load;
  logic [3:0] ld_tens;
  logic [3:0] ld_ones;
  logic [3:0] nxt_tens;
  logic [3:0] nxt_ones;
  logic       nxt_carry;

  // tick_d resets high so a level already high at reset release is not an edge.
  assign step    = en & tick_in & ~tick_d;
  assign at_max  = (tens == TENS_MAX) && (ones == ONES_MAX);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);

`ifdef BCD_CNT_LOAD_EN
  logic [6:0] ld_bin;
  assign ld_tens = load_val[7:4];
  assign ld_ones = load_val[3:0];
  assign ld_bin  = 7'(ld_tens) * 7'd10 + 7'(ld_ones);
  // Only BCD-clean values inside the count range are accepted.
  assign do_load = load && (ld_tens <= 4'd9) && (ld_ones <= 4'd9) &&
                   (ld_bin < 7'(MODULUS));
`else
  assign ld_tens = 4'd0;
  assign ld_ones = 4'd0;
  assign do_load = 1'b0;
`endif

  // Next count: clr > load > step > hold; carry only on a wrapping step.
  always_comb begin
    nxt_tens  = tens;
    nxt_ones  = ones;
    nxt_carry = 1'b0;
    if (clr) begin
      nxt_tens = 4'd0;
      nxt_ones = 4'd0;
    end else if (do_load) begin
      nxt_tens = ld_tens;
      nxt_ones = ld_ones;
    end else if (step) begin
      if (up) begin
        if (at_max) begin
          nxt_tens  = 4'd0;
          nxt_ones  = 4'd0;
          nxt_carry = 1'b1;
        end else if (ones == 4'd9) begin
          nxt_ones = 4'd0;
          nxt_tens = tens + 4'd1;
        end else begin
          nxt_ones = ones + 4'd1;
        end
      end else begin
        if (at_zero) begin
          nxt_tens  = TENS_MAX;
          nxt_ones  = ONES_MAX;
          nxt_carry = 1'b1;
        end else if (ones == 4'd0) begin
          nxt_ones = 4'd9;
          nxt_tens = tens - 4'd1;
        end else begin
          nxt_ones = ones - 4'd1;
        end
      end
    end
  end

  // Edge history tracks tick_in every cycle, independent of en/clr/load.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) tick_d <= 1'b1;
    else          tick_d <= tick_in;
  end

  // Count and carry registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      tens  <= 4'd0;
      ones  <= 4'd0;
      carry <= 1'b0;
    end else begin
      tens  <= nxt_tens;
      ones  <= nxt_ones;
      carry <= nxt_carry;
    end
  end

endmodule
